dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences MEM-stage data-memory accesses for the 5-stage pipeline against a variable-latency memory (req/ack).
//  Sits between the EX/MEM register outputs and data memory.
//  Asserts Stall to freeze PC, IF/ID, ID/EX and EX/MEM until the access completes.
//  Delivers ReadDataMEM to the MEM/WB register.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  16  max BUSY cycles without mem_ack before abort (>=1)
//  TO_W     $clog2(TIMEOUT+1)  timeout counter width (derived, localparam)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  MemReadMEM   in   1       load in MEM stage
//  MemWriteMEM  in   1       store in MEM stage
//  Address      in   ADDR_W  byte address from EX/MEM
//  WriteDataMEM in   DATA_W  store data from EX/MEM
//  mem_ack      in   1       memory completes current request (1-cycle pulse)
//  mem_rdata    in   DATA_W  load data, valid with mem_ack
//  mem_req      out  1       request to memory, held until ack/abort
//  mem_we       out  1       1=write, 0=read
//  mem_addr     out  ADDR_W  registered request address
//  mem_wdata    out  DATA_W  registered store data
//  Stall        out  1       freeze upstream pipeline registers
//  ReadDataMEM  out  DATA_W  load result to MEM/WB
//  TimeoutErr   out  1       1-cycle pulse on access abort
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE.
//   mem_req, mem_we, Stall, TimeoutErr = 0; mem_addr, mem_wdata, ReadDataMEM = 0; counter = 0.
//  access = MemReadMEM | MemWriteMEM. Write wins if both are set; ReadDataMEM then = 0.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: Stall = access (combinational).
//    On access: latch mem_addr = {Address[ADDR_W-1:2],2'b00}, mem_wdata, mem_we = MemWriteMEM.
//    Clear counter. -> BUSY.
//   BUSY: mem_req=1, Stall=1, counter increments each cycle.
//    mem_ack: ReadDataMEM <= mem_we ? 0 : mem_rdata. -> DONE.
//    Timeout: no ack and counter==TIMEOUT-1 -> ReadDataMEM <= 32'hDEAD_BEEF, TimeoutErr=1 next cycle, -> DONE.
//    ack in the timeout cycle: ack wins, no error.
//   DONE: Stall=0, mem_req=0. The served instruction leaves MEM on this edge. -> IDLE unconditionally.
//    Inputs are ignored in DONE, so the same access is never reissued.
//  Timing: no access = 0 stall cycles.
//   Access with ack on the first BUSY cycle = 2 stall cycles (IDLE, BUSY).
//   Each extra ack wait cycle adds 1 stall cycle.
//  ReadDataMEM holds its value until the next completion.
//  mem_addr, mem_wdata and mem_we are stable while mem_req=1.
//  mem_ack outside BUSY is ignored.
//  Reset mid-access: immediate return to IDLE with all outputs at reset values. An outstanding memory transaction is dropped.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   IDLE access with Address[1:0]!=0 issues no memory request. Goes IDLE -> DONE (Stall=1 for 1 cycle).
//   Adds output MisalignErr (1-cycle pulse, reset 0) and sets ReadDataMEM = 0.
//  MISALIGN_TRAP_EN undefined: Address[1:0] is silently dropped (word-aligned access). Port MisalignErr is absent.
// TESTING
//  1. Idle pipeline, MemRead=MemWrite=0 for 10 cycles -> Stall=0, mem_req=0 throughout.
//  2. Load, Address=0x0000_0010, mem_ack in 1st BUSY cycle, mem_rdata=0x1234_5678
//     -> Stall high 2 cycles, mem_we=0, mem_addr=0x10, ReadDataMEM=0x1234_5678 in DONE.
//  3. Store, Address=0x20, WriteData=0xCAFE_F00D, ack after 4 cycles
//     -> mem_we=1, mem_wdata stable for 4 cycles, Stall high 5 cycles, ReadDataMEM=0.
//  4. Load with no ack, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles,
//     TimeoutErr pulses once, ReadDataMEM=0xDEAD_BEEF, FSM back in IDLE.
//  5. Assert reset=0 on the 2nd BUSY cycle -> all outputs 0 immediately.
//     Next access after release completes normally.
//  6. MISALIGN_TRAP_EN on, load at Address=0x13 -> no mem_req, MisalignErr pulse, 1 stall cycle.
//     MISALIGN_TRAP_EN off -> mem_addr=0x10.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack accesses, stalls the pipeline, aborts on timeout.
// Build option MISALIGN_TRAP_EN: trap misaligned accesses (adds MisalignErr) instead of word-aligning them.
//
// state | meaning
// IDLE  | waiting for a load/store; Stall follows the access request combinationally
// BUSY  | mem_req held, counting cycles towards the timeout abort
// DONE  | access finished, pipeline released for one cycle, inputs ignored
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadMEM,
  input  logic              MemWriteMEM,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteDataMEM,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              Stall,
  output logic [DATA_W-1:0] ReadDataMEM,
  output logic              TimeoutErr
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              MisalignErr
`endif
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);
  localparam logic [TO_W-1:0]   CNT_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            access;
  logic            misaligned;
  logic            timeout_hit;
  logic [TO_W-1:0] cnt;

  assign access = MemReadMEM | MemWriteMEM;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (Address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // An ack arriving in the last allowed cycle takes priority over the abort.
  assign timeout_hit = (state == BUSY) && !mem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (access) begin
          state_nxt = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (mem_ack || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Stall   = 1'b0;
    mem_req = 1'b0;
    case (state)
      IDLE: Stall = access;
      BUSY: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
      end
      default: begin
        Stall   = 1'b0;
        mem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cnt         <= '0;
      ReadDataMEM <= '0;
      TimeoutErr  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
    end else begin
      TimeoutErr <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= Address & ALIGN_MASK;
            mem_wdata <= WriteDataMEM;
            mem_we    <= MemWriteMEM;
            cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              ReadDataMEM <= '0;
              MisalignErr <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          cnt <= cnt + TO_W'(1);
          if (mem_ack) begin
            ReadDataMEM <= mem_we ? '0 : mem_rdata;
          end else if (timeout_hit) begin
            ReadDataMEM <= ABORT_DATA;
            TimeoutErr  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: scoreboard of expected access outcomes, checked at completion.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadMEM = 1'b0;
  logic        MemWriteMEM = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteDataMEM = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        Stall;
  logic [31:0] ReadDataMEM;
  logic        TimeoutErr;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignErr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        terr;
    logic        merr;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemReadMEM  (MemReadMEM),
    .MemWriteMEM (MemWriteMEM),
    .Address     (Address),
    .WriteDataMEM(WriteDataMEM),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .Stall       (Stall),
    .ReadDataMEM (ReadDataMEM),
    .TimeoutErr  (TimeoutErr)
`ifdef MISALIGN_TRAP_EN
    ,
    .MisalignErr (MisalignErr)
`endif
  );

  task automatic test_reset();
    #2;
    n_tests++;
    if ({mem_req, mem_we, Stall, TimeoutErr, mem_addr, mem_wdata, ReadDataMEM} !== 99'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%0b we=%0b stall=%0b terr=%0b addr=%h wdata=%h rdata=%h, want all 0",
               mem_req, mem_we, Stall, TimeoutErr, mem_addr, mem_wdata, ReadDataMEM);
    end
`ifdef MISALIGN_TRAP_EN
    n_tests++;
    if (MisalignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misalign: got %0b, want 0", MisalignErr);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({Stall, mem_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got stall=%0b req=%0b, want 0 0", i, Stall, mem_req);
      end
      // Stray ack while idle must not be captured.
      mem_ack   = (i == 4);
      mem_rdata = (i == 4) ? 32'h7777_7777 : 32'h0;
    end
    n_tests++;
    if (ReadDataMEM !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_stray_ack: got rdata=%h, want 00000000", ReadDataMEM);
    end
  endtask

  // ack_at: BUSY cycle (1-based) on which mem_ack is pulsed; 0 means never.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    exp_t e;
    exp_t got;
    int   stalls = 0;
    int   reqs = 0;
    bit   done = 0;
    e.we    = wr;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = wdata;
    e.terr  = 1'b0;
    e.merr  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (addr[1:0] != 2'b00) begin
      e.stalls = 1; e.reqs = 0; e.rdata = 32'h0; e.merr = 1'b1;
    end else
`endif
    if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      e.stalls = ack_at + 1; e.reqs = ack_at; e.rdata = wr ? 32'h0 : rdata;
    end else begin
      e.stalls = TIMEOUT + 1; e.reqs = TIMEOUT; e.rdata = 32'hDEAD_BEEF; e.terr = 1'b1;
    end
    sb.push_back(e);

    @(posedge clk); #1;
    MemReadMEM = rd; MemWriteMEM = wr; Address = addr; WriteDataMEM = wdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (Stall) begin
        stalls++;
        if (mem_req) begin
          reqs++;
          n_tests++;
          if ({mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
            n_fail++;
            $display("FAIL req_fields: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
          end
          if (reqs == ack_at) begin
            mem_ack = 1'b1; mem_rdata = rdata;
          end else begin
            mem_rdata = $urandom;
          end
        end
      end else begin
        done = 1;
        got = sb.pop_front();
        n_tests++;
        if (stalls != got.stalls || reqs != got.reqs) begin
          n_fail++;
          $display("FAIL stall_count: got stalls=%0d reqs=%0d, want stalls=%0d reqs=%0d",
                   stalls, reqs, got.stalls, got.reqs);
        end
        n_tests++;
        if ({ReadDataMEM, TimeoutErr, mem_req} !== {got.rdata, got.terr, 1'b0}) begin
          n_fail++;
          $display("FAIL done_outputs: got rdata=%h terr=%0b req=%0b, want rdata=%h terr=%0b req=0",
                   ReadDataMEM, TimeoutErr, mem_req, got.rdata, got.terr);
        end
`ifdef MISALIGN_TRAP_EN
        n_tests++;
        if (MisalignErr !== got.merr) begin
          n_fail++;
          $display("FAIL misalign_err: got %0b, want %0b", MisalignErr, got.merr);
        end
`endif
        MemReadMEM = 1'b0; MemWriteMEM = 1'b0;
      end
      if (!done) begin
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_wait: stalls=%0d reqs=%0d, want completion within 64 cycles", stalls, reqs);
      MemReadMEM = 1'b0; MemWriteMEM = 1'b0; mem_ack = 1'b0;
      void'(sb.pop_front());
    end
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1);
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5A5A_5A5A, 4);
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({TimeoutErr, Stall, mem_req, ReadDataMEM} !== {3'b000, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL timeout_after: got terr=%0b stall=%0b req=%0b rdata=%h, want 0 0 0 deadbeef",
               TimeoutErr, Stall, mem_req, ReadDataMEM);
    end
  endtask

  task automatic test_ack_at_timeout();
    run_access(1'b1, 1'b0, 32'h0000_0034, 32'h0, 32'hA5A5_0001, TIMEOUT);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0101_0101, 1);
    run_access(1'b0, 1'b1, 32'h0000_0104, 32'h0F0F_0F0F, 32'h0, 3);
    run_access(1'b1, 1'b1, 32'h0000_0108, 32'h3333_4444, 32'h9999_9999, 2);
    run_access(1'b1, 1'b0, 32'h0000_010C, 32'h0, 32'hBEEF_0042, 5);
  endtask

  task automatic test_reset_mid();
    int busy = 0;
    @(posedge clk); #1;
    MemWriteMEM = 1'b1; Address = 32'h0000_0040; WriteDataMEM = 32'hAAAA_5555;
    for (int cyc = 0; cyc < 8 && busy < 2; cyc++) begin
      @(negedge clk);
      if (mem_req) busy++;
    end
    n_tests++;
    if (busy != 2) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got %0d busy cycles, want 2", busy);
    end
    reset = 1'b0;
    MemWriteMEM = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, mem_we, Stall, TimeoutErr, mem_addr, mem_wdata, ReadDataMEM} !== 99'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got req=%0b we=%0b stall=%0b terr=%0b addr=%h wdata=%h rdata=%h, want all 0",
               mem_req, mem_we, Stall, TimeoutErr, mem_addr, mem_wdata, ReadDataMEM);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 2);
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h1111_2222, 1);
    run_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'h2222_3333, 1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
